// File: rtl/behavioral_input_pad_filter.sv
// Input pad filter: synchroniser, debounce FSM and edge pulses in the HCLK domain.
// Optional rejected-glitch counter enabled by defining INPUT_PAD_GLITCH_CNT_EN.
module behavioral_input_pad_filter #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       PIN,
    input  logic       EN,
`ifdef INPUT_PAD_GLITCH_CNT_EN
    input  logic       GLITCH_CLR,
    output logic [7:0] GLITCH_CNT,
`endif
    output logic       POUT,
    output logic       RISE,
    output logic       FALL
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   pout_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PIN};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            pout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!EN) begin
                // Disabling abandons any pending change without counting it.
                state_q <= ST_STABLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_STABLE: begin
                        if (s != pout_q) begin
                            state_q <= ST_CHECK;
                            cnt_q   <= '0;
                        end
                    end
                    ST_CHECK: begin
                        if (s == pout_q) begin
                            state_q <= ST_STABLE;
                        end else if (cnt_q == CNT_LAST) begin
                            pout_q  <= s;
                            rise_q  <= s;
                            fall_q  <= ~s;
                            state_q <= ST_STABLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_STABLE;
                endcase
            end
        end
    end

    assign POUT = pout_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

`ifdef INPUT_PAD_GLITCH_CNT_EN
    logic       glitch_rej;
    logic [7:0] gcnt_q;
    logic [7:0] gcnt_d;

    assign glitch_rej = EN && (state_q == ST_CHECK) && (s == pout_q);

    always_comb begin
        gcnt_d = gcnt_q;
        if (GLITCH_CLR) begin
            gcnt_d = 8'd0;
        end else if (glitch_rej && (gcnt_q != 8'hFF)) begin
            gcnt_d = gcnt_q + 8'd1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gcnt_q <= 8'd0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign GLITCH_CNT = gcnt_q;
`endif

endmodule
